// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory between the load/store unit (port 0)
// and the debug/DMA loader (port 1); one request in flight, fixed 3-cycle turnaround.
module data_mem_arbiter #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rdata,
   output logic              resp0_err,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rdata,
   output logic              resp1_err,
   output logic [ADDR_W-1:0] mem_data_address,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state;
   logic              last_grant;
   logic              lat_port;
   logic              lat_in_range;
   logic              grant0_c;
   logic              grant1_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;
   logic              sel_we_c;
   logic              sel_in_range_c;
   logic [DATA_W-1:0] cap_rdata_c;

   // Grant only in IDLE; under contention the port that did not win last time goes first.
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant)) grant0_c = 1'b1;
         else if (req1_valid)                           grant1_c = 1'b1;
      end
   end

   assign req0_ready     = grant0_c;
   assign req1_ready     = grant1_c;
   assign sel_addr_c     = grant1_c ? req1_addr  : req0_addr;
   assign sel_wdata_c    = grant1_c ? req1_wdata : req0_wdata;
   assign sel_we_c       = grant1_c ? req1_we    : req0_we;
   assign sel_in_range_c = 32'(sel_addr_c) < DEPTH;
   assign cap_rdata_c    = lat_in_range ? mem_read_data : DATA_W'(0);

   // Memory lines are loaded at the handshake so they are live for exactly the ACCESS cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         last_grant        <= 1'b1;
         lat_port          <= 1'b0;
         lat_in_range      <= 1'b0;
         mem_data_address  <= '0;
         mem_write_address <= '0;
         mem_write_en      <= 1'b0;
         mem_write_data    <= '0;
         resp0_valid       <= 1'b0;
         resp0_rdata       <= '0;
         resp0_err         <= 1'b0;
         resp1_valid       <= 1'b0;
         resp1_rdata       <= '0;
         resp1_err         <= 1'b0;
      end else begin
         mem_data_address  <= '0;
         mem_write_address <= '0;
         mem_write_en      <= 1'b0;
         mem_write_data    <= '0;
         resp0_valid       <= 1'b0;
         resp0_rdata       <= '0;
         resp0_err         <= 1'b0;
         resp1_valid       <= 1'b0;
         resp1_rdata       <= '0;
         resp1_err         <= 1'b0;
         case (state)
            IDLE: begin
               if (grant0_c || grant1_c) begin
                  lat_port          <= grant1_c;
                  last_grant        <= grant1_c;
                  lat_in_range      <= sel_in_range_c;
                  mem_data_address  <= sel_addr_c;
                  mem_write_address <= sel_addr_c;
                  mem_write_en      <= sel_we_c & sel_in_range_c;
                  mem_write_data    <= sel_wdata_c;
                  state             <= ACCESS;
               end
            end
            ACCESS: begin
               // Read data is sampled before the write edge, so stores return old contents.
               if (lat_port) begin
                  resp1_valid <= 1'b1;
                  resp1_rdata <= cap_rdata_c;
                  resp1_err   <= ~lat_in_range;
               end else begin
                  resp0_valid <= 1'b1;
                  resp0_rdata <= cap_rdata_c;
                  resp0_err   <= ~lat_in_range;
               end
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: table of single requests, contention, reset abort and idle checks.
module tb_data_mem_arbiter;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0_valid = 1'b0, req0_ready, req0_we = 1'b0;
   logic [ADDR_W-1:0] req0_addr = '0;
   logic [DATA_W-1:0] req0_wdata = '0;
   logic              req1_valid = 1'b0, req1_ready, req1_we = 1'b0;
   logic [ADDR_W-1:0] req1_addr = '0;
   logic [DATA_W-1:0] req1_wdata = '0;
   logic              resp0_valid, resp0_err, resp1_valid, resp1_err;
   logic [DATA_W-1:0] resp0_rdata, resp1_rdata;
   logic [ADDR_W-1:0] mem_data_address, mem_write_address;
   logic              mem_write_en;
   logic [DATA_W-1:0] mem_write_data, mem_read_data;

   data_mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
      .mem_data_address(mem_data_address), .mem_write_en(mem_write_en),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory with combinational read; out-of-range reads return junk the DUT must mask.
   logic [DATA_W-1:0] ram [DEPTH];
   assign mem_read_data = (32'(mem_data_address) < DEPTH) ? ram[mem_data_address[7:0]] : 32'hBAD0BAD0;
   always @(posedge clk)
      if (mem_write_en && 32'(mem_write_address) < DEPTH) ram[mem_write_address[7:0]] <= mem_write_data;

   typedef struct {
      bit                port;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
      bit                exp_err;
   } vec_t;

   typedef struct {
      bit                port;
      logic [DATA_W-1:0] rdata;
      bit                err;
      int                cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   writes = 0;
   int   exp_writes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response scoreboard and write monitor, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (resp0_valid || resp1_valid) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", 64'(resp0_valid | resp1_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("resp_port", 64'(resp1_valid), 64'(e.port));
            check("resp_other_quiet", 64'(e.port ? resp0_valid : resp1_valid), 64'd0);
            check("resp_rdata", 64'(e.port ? resp1_rdata : resp0_rdata), 64'(e.rdata));
            check("resp_err", 64'(e.port ? resp1_err : resp0_err), 64'(e.err));
            check("resp_latency", 64'(cyc), 64'(e.cyc + 2));
         end
      end
      if (mem_write_en) begin
         writes++;
         check("wr_addr_match", 64'(mem_write_address), 64'(mem_data_address));
         check("wr_in_range", 64'(32'(mem_write_address) < DEPTH), 64'd1);
      end
   end

   task automatic drive(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input bit valid);
      if (port) begin
         req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata;
      end else begin
         req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(posedge clk); #2;
      end
      check("resp_drain", 64'(sb.size()), 64'd0);
      @(posedge clk); #2;
   endtask

   task automatic do_req(input vec_t v);
      bit   got;
      exp_t e;
      got = 1'b0;
      drive(v.port, v.we, v.addr, v.wdata, 1'b1);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (v.port ? req1_ready : req0_ready) begin
            got = 1'b1;
            check("ready_first_cycle", 64'(i), 64'd0);
            check("ready_other_low", 64'(v.port ? req0_ready : req1_ready), 64'd0);
            e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err; e.cyc = cyc;
            sb.push_back(e);
            if (v.we && !v.exp_err) exp_writes++;
         end
      end
      check("req_accept", 64'(got), 64'd1);
      @(posedge clk); #1;
      drive(v.port, 1'b0, '0, '0, 1'b0);
      drain();
   endtask

   vec_t vecs[$];

   initial begin
      exp_t e;
      bit   exp_p;
      int   g;
      int   prev;
      bit   got;

      vecs.push_back('{0, 0, 15'd5,    32'h0,        32'd5,        0});
      vecs.push_back('{1, 1, 15'd10,   32'hDEADBEEF, 32'd10,       0});
      vecs.push_back('{0, 0, 15'd10,   32'h0,        32'hDEADBEEF, 0});
      vecs.push_back('{0, 1, 15'd300,  32'h1234,     32'd0,        1});
      vecs.push_back('{0, 0, 15'd44,   32'h0,        32'd44,       0});
      vecs.push_back('{1, 0, 15'd255,  32'h0,        32'd255,      0});
      vecs.push_back('{1, 0, 15'd256,  32'h0,        32'd0,        1});
      vecs.push_back('{1, 1, 15'd255,  32'hA5A5A5A5, 32'd255,      0});
      vecs.push_back('{0, 0, 15'd255,  32'h0,        32'hA5A5A5A5, 0});
      vecs.push_back('{1, 1, 15'd256,  32'h77,       32'd0,        1});
      vecs.push_back('{1, 0, 15'h7FFF, 32'h0,        32'd0,        1});

      for (int i = 0; i < int'(DEPTH); i++) ram[i] = 32'(i);

      #1;
      check("rst_mem_we", 64'(mem_write_en), 64'd0);
      check("rst_mem_addr", 64'(mem_data_address | mem_write_address), 64'd0);
      check("rst_resp", 64'({resp0_valid, resp1_valid, resp0_err, resp1_err}), 64'd0);
      check("rst_rdata", 64'(resp0_rdata | resp1_rdata), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) do_req(vecs[i]);
      check("ram_10_written", 64'(ram[10]), 64'hDEADBEEF);

      // Continuous contention: last table grant was port 1, so port 0 goes first.
      drive(1'b0, 1'b0, 15'd1, '0, 1'b1);
      drive(1'b1, 1'b0, 15'd2, '0, 1'b1);
      exp_p = 1'b0; g = 0; prev = 0;
      for (int i = 0; i < 40 && g < 6; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            check("cont_one_ready", 64'(req0_ready & req1_ready), 64'd0);
            check("cont_order", 64'(req1_ready), 64'(exp_p));
            if (g > 0) check("cont_spacing", 64'(cyc - prev), 64'd3);
            e.port = req1_ready; e.rdata = req1_ready ? 32'd2 : 32'd1; e.err = 1'b0; e.cyc = cyc;
            sb.push_back(e);
            exp_p = ~exp_p; prev = cyc; g++;
         end
      end
      check("cont_grants", 64'(g), 64'd6);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      drain();

      // Reset during ACCESS of a port 1 load aborts it.
      drive(1'b1, 1'b0, 15'd7, '0, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = req1_ready;
      end
      check("abort_accept", 64'(got), 64'd1);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      check("abort_in_access", 64'(mem_data_address), 64'd7);
      rst_n = 1'b0;
      #1;
      check("abort_mem_addr", 64'(mem_data_address | mem_write_address), 64'd0);
      check("abort_outs", 64'({mem_write_en, resp0_valid, resp1_valid, resp0_err, resp1_err}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("abort_no_resp", 64'({resp0_valid, resp1_valid}), 64'd0);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 15'd3, '0, 1'b1);
      drive(1'b1, 1'b0, 15'd4, '0, 1'b1);
      @(negedge clk);
      check("post_rst_grant0", 64'({req0_ready, req1_ready}), 64'b10);
      e.port = 1'b0; e.rdata = 32'd3; e.err = 1'b0; e.cyc = cyc;
      sb.push_back(e);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, 1'b0);
      drain();

      // Quiet bus for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_quiet", 64'({req0_ready, req1_ready, mem_write_en, resp0_valid, resp1_valid,
                                  resp0_err, resp1_err}), 64'd0);
         check("idle_rdata", 64'(resp0_rdata | resp1_rdata), 64'd0);
      end

      check("write_count", 64'(writes), 64'(exp_writes));
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
